// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its storage sub-module.
package sync_fifo_pkg;

    // Address width: the FIFO holds 2**BUF_WIDTH entries.
    localparam int BUF_WIDTH_DEF  = 3;
    // Stored word width.
    localparam int DATA_WIDTH_DEF = 8;
    // Number of entries for the default address width.
    localparam int DEPTH_DEF      = 2 ** BUF_WIDTH_DEF;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port.
// There is no reset, so it maps onto inferred block RAM.  A read and a
// write to the same address on the same edge return the old contents.
import sync_fifo_pkg::*;

module sync_fifo_ram #(
    parameter int ADDR_WIDTH = BUF_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    // Write port: store the incoming word when the write is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read port: registered; holds its value while no read is enabled.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule : sync_fifo_ram

// File: rtl/sync_fifo.sv
// Synchronous first-in first-out buffer with occupancy counter and
// empty/full flags.  Pointers, counter and flags live here; the word
// storage is in sync_fifo_ram.
import sync_fifo_pkg::*;

module sync_fifo #(
    parameter int BUF_WIDTH  = BUF_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
    output logic [BUF_WIDTH:0]    fifo_counter
);

    localparam int AW    = BUF_WIDTH;
    localparam int CW    = BUF_WIDTH + 1;
    localparam int DEPTH = 2 ** BUF_WIDTH;

    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // A write into a full FIFO is still taken when a read frees the slot
    // on the same edge; a read from an empty FIFO is never taken.
    always_comb begin
        wr_ok = wr_en & (~buf_full | rd_en);
        rd_ok = rd_en & ~buf_empty;
    end

    // Pointer, occupancy and output-valid state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                out_valid_reg <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    sync_fifo_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we      (wr_ok),
        .wr_addr (wr_ptr_reg),
        .wr_data (buf_in),
        .re      (rd_ok),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_q)
    );

    // The RAM read register cannot be reset, so the output is forced to
    // zero from reset until the first accepted read reloads it.
    always_comb begin
        buf_out      = out_valid_reg ? ram_q : '0;
        fifo_counter = count_reg;
        buf_empty    = (count_reg == '0);
        buf_full     = (count_reg == CW'(DEPTH));
    end

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default 8 x 8 configuration).
`timescale 1ns/1ps

module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [3:0] fifo_counter;

    int n_cmp = 0;
    int n_err = 0;

    sync_fifo #(
        .BUF_WIDTH  (3),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; returns 1ns after the rising edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        $display("cycle wr=%0b rd=%0b in=%0d -> out=%0d cnt=%0d empty=%0b full=%0b",
                 w, r, d, buf_out, fifo_counter, buf_empty, buf_full);
    endtask

    initial begin
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        buf_in = '0;
        #2;
        check("rst_out",   32'(buf_out), 0);
        check("rst_cnt",   32'(fifo_counter), 0);
        check("rst_empty", 32'(buf_empty), 1);
        check("rst_full",  32'(buf_full), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // push 1, then push 2 with a simultaneous pop
        step(1'b1, 1'b0, 8'd1);
        check("push1_cnt",   32'(fifo_counter), 1);
        check("push1_empty", 32'(buf_empty), 0);
        step(1'b1, 1'b1, 8'd2);
        check("rw_out", 32'(buf_out), 1);
        check("rw_cnt", 32'(fifo_counter), 1);

        // fill with 10..70 on top of the remaining 2
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 8'(10 * i));
            check("fill_cnt", 32'(fifo_counter), 32'(i + 1));
        end
        check("full_flag", 32'(buf_full), 1);
        step(1'b1, 1'b0, 8'd130);
        check("ovf_cnt",  32'(fifo_counter), 8);
        check("ovf_full", 32'(buf_full), 1);

        // push and pop together while full
        step(1'b1, 1'b1, 8'd80);
        check("fullrw_out",  32'(buf_out), 2);
        check("fullrw_cnt",  32'(fifo_counter), 8);
        check("fullrw_full", 32'(buf_full), 1);

        // drain: 10..80 in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("drain_out", 32'(buf_out), 32'(10 * i));
            check("drain_cnt", 32'(fifo_counter), 32'(8 - i));
        end
        check("drain_empty", 32'(buf_empty), 1);
        step(1'b0, 1'b1, 8'd0);
        check("udf_out", 32'(buf_out), 80);
        check("udf_cnt", 32'(fifo_counter), 0);

        // pop while empty with simultaneous push: only the push is taken
        step(1'b1, 1'b1, 8'd55);
        check("erw_out", 32'(buf_out), 80);
        check("erw_cnt", 32'(fifo_counter), 1);
        step(1'b0, 1'b1, 8'd0);
        check("erw_pop", 32'(buf_out), 55);

        // many push/pop pairs so both pointers wrap more than twice
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 8'(5 + k));
            step(1'b0, 1'b1, 8'd0);
            check("wrap_out", 32'(buf_out), 32'(5 + k));
            check("wrap_cnt", 32'(fifo_counter), 0);
        end

        // store 4 entries, then reset asynchronously mid-cycle
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'(11 + i));
        end
        check("pre_rst_cnt", 32'(fifo_counter), 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out",   32'(buf_out), 0);
        check("arst_cnt",   32'(fifo_counter), 0);
        check("arst_empty", 32'(buf_empty), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 8'd7);
        check("post_push_cnt", 32'(fifo_counter), 1);
        step(1'b0, 1'b1, 8'd0);
        check("post_pop_out", 32'(buf_out), 7);
        check("post_pop_cnt", 32'(fifo_counter), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sync_fifo
